// File: rtl/tone_pkg.sv
// ============================================================================
// tone_pkg : shared widths and debounce state encoding for the tone path
// Rev 1.0
// ============================================================================
`default_nettype none

package tone_pkg;
    localparam int NOTE_W   = 4;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAND = 2'd1,
        HELD = 2'd2
    } deb_state_t;
endpackage

`default_nettype wire

// File: rtl/key_debouncer.sv
// ============================================================================
// key_debouncer : frame-rate press/release debounce producing note code,
//                 hold enable and a single-cycle press strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module key_debouncer
    import tone_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_end,
    input  logic              valid,
    input  logic [NOTE_W-1:0] code,
    output logic [NOTE_W-1:0] B_out,
    output logic              EN_out,
    output logic              KEY_PRESS
);
    localparam logic [7:0] C_DEB = 8'(DEBOUNCE_CNT);

    deb_state_t        r_state, w_state;
    logic [7:0]        r_cnt, w_cnt;
    logic [7:0]        r_rcnt, w_rcnt;
    logic [NOTE_W-1:0] r_cand, w_cand;
    logic [NOTE_W-1:0] r_b, w_b;
    logic              r_en, w_en;
    logic              r_kp, w_kp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_rcnt  <= 8'd0;
            r_cand  <= '0;
            r_b     <= '0;
            r_en    <= 1'b0;
            r_kp    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_rcnt  <= w_rcnt;
            r_cand  <= w_cand;
            r_b     <= w_b;
            r_en    <= w_en;
            r_kp    <= w_kp;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_rcnt  = r_rcnt;
        w_cand  = r_cand;
        w_b     = r_b;
        w_en    = r_en;
        w_kp    = 1'b0;
        if (frame_end) begin
            case (r_state)
                IDLE: begin
                    if (valid) begin
                        if (C_DEB == 8'd1) begin
                            w_state = HELD;
                            w_b     = code;
                            w_en    = 1'b1;
                            w_kp    = 1'b1;
                            w_rcnt  = 8'd0;
                            w_cnt   = C_DEB;
                        end else begin
                            w_state = CAND;
                            w_cand  = code;
                            w_cnt   = 8'd1;
                        end
                    end
                end
                CAND: begin
                    if (!valid) begin
                        w_state = IDLE;
                        w_cnt   = 8'd0;
                    end else if (code == r_cand) begin
                        w_cnt = r_cnt + 8'd1;
                        if (w_cnt == C_DEB) begin
                            w_state = HELD;
                            w_b     = r_cand;
                            w_en    = 1'b1;
                            w_kp    = 1'b1;
                            w_rcnt  = 8'd0;
                        end
                    end else begin
                        w_cand = code;
                        w_cnt  = 8'd1;
                    end
                end
                HELD: begin
                    if (valid && code == r_b) begin
                        w_rcnt = 8'd0;
                    end else begin
                        w_rcnt = r_rcnt + 8'd1;
                        // B_out is deliberately left at the released key's code
                        if (w_rcnt == C_DEB) begin
                            w_state = IDLE;
                            w_en    = 1'b0;
                            w_cnt   = 8'd0;
                        end
                    end
                end
                default: w_state = IDLE;
            endcase
        end
    end

    assign B_out     = r_b;
    assign EN_out    = r_en;
    assign KEY_PRESS = r_kp;
endmodule

`default_nettype wire

// File: rtl/key_matrix_scanner.sv
// ============================================================================
// key_matrix_scanner : 4x4 matrix column scan, row synchroniser, frame
//                      encoder and debounced note output
// Rev 1.0
// ============================================================================
`default_nettype none

module key_matrix_scanner
    import tone_pkg::*;
#(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NUM_ROWS-1:0] ROW_in,
    output logic [NUM_COLS-1:0] COL_out,
    output logic [NOTE_W-1:0]   B_out,
    output logic                EN_out,
    output logic                KEY_PRESS
);
    localparam int          NUM_KEYS   = NUM_ROWS * NUM_COLS;
    localparam logic [15:0] C_DIV_LAST = 16'(SCAN_DIV - 1);

    logic [1:0]          r_rst_pipe;
    logic                w_rst_n;
    logic [15:0]         r_div;
    logic [1:0]          r_col;
    logic [NUM_ROWS-1:0] r_row_meta, r_row_sync;
    logic [NUM_KEYS-1:0] r_keys, w_merged;
    logic                w_sample, w_frame_end, w_valid;
    logic [NOTE_W-1:0]   w_code;

    // Assert asynchronously, release on a clock edge
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_rst_pipe <= 2'b00;
        else        r_rst_pipe <= {r_rst_pipe[0], 1'b1};
    end
    assign w_rst_n = r_rst_pipe[1];

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_div <= 16'd0;
            r_col <= 2'd0;
        end else if (r_div == C_DIV_LAST) begin
            r_div <= 16'd0;
            r_col <= r_col + 2'd1;
        end else begin
            r_div <= r_div + 16'd1;
        end
    end

    assign COL_out = ~(4'b0001 << r_col);

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_row_meta <= '1;
            r_row_sync <= '1;
        end else begin
            r_row_meta <= ROW_in;
            r_row_sync <= r_row_meta;
        end
    end

    assign w_sample    = (r_div == C_DIV_LAST);
    assign w_frame_end = w_sample && (r_col == 2'd3);

    // Fold the current column's sample in so the frame-end view includes column 3
    always_comb begin
        w_merged = r_keys;
        if (w_sample) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (!r_row_sync[r]) w_merged[{r_col, 2'(r)}] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n)         r_keys <= '0;
        else if (w_frame_end) r_keys <= '0;
        else if (w_sample)    r_keys <= w_merged;
    end

    always_comb begin
        w_valid = |w_merged;
        w_code  = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (w_merged[i]) w_code = 4'(i);
        end
    end

    key_debouncer #(
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_debouncer (
        .clk       (CLK),
        .rst_n     (w_rst_n),
        .frame_end (w_frame_end),
        .valid     (w_valid),
        .code      (w_code),
        .B_out     (B_out),
        .EN_out    (EN_out),
        .KEY_PRESS (KEY_PRESS)
    );
endmodule

`default_nettype wire

// File: tb/tb_key_matrix_scanner.sv
// ============================================================================
// tb_key_matrix_scanner : frame-level model of the scanner driven by a
//                         behavioural key matrix
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_key_matrix_scanner;
    localparam int SD = 4;
    localparam int DB = 3;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  b;
    logic        en;
    logic        kp;
    logic [15:0] keys = 16'h0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Frame-level reference state
    bit m_held = 0;
    int m_b    = 0;
    int m_run  = 0;
    int m_rcode = -1;
    int m_rel  = 0;

    always #5 clk = ~clk;

    // Passive matrix: a closed switch pulls its row low when its column is driven
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[c*4 + r] && !col[c]) row[r] = 1'b0;
    end

    key_matrix_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .ROW_in    (row),
        .COL_out   (col),
        .B_out     (b),
        .EN_out    (en),
        .KEY_PRESS (kp)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int low_code(input logic [15:0] k);
        for (int i = 0; i < 16; i++) if (k[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_held = 0; m_b = 0; m_run = 0; m_rcode = -1; m_rel = 0;
    endtask

    task automatic model_frame(input logic [15:0] k, output int exp_kp);
        int code;
        code = low_code(k);
        exp_kp = 0;
        if (!m_held) begin
            if (code < 0) begin
                m_run = 0;
            end else begin
                if (m_run > 0 && code == m_rcode) m_run++;
                else begin m_rcode = code; m_run = 1; end
                if (m_run == DB) begin
                    m_held = 1; m_b = code; m_rel = 0; exp_kp = 1;
                end
            end
        end else begin
            if (code == m_b) m_rel = 0;
            else m_rel++;
            if (m_rel == DB) begin m_held = 0; m_run = 0; end
        end
    endtask

    // Called just after a frame-start edge; returns just after the next one
    task automatic run_frame(input logic [15:0] k, input string tag);
        int kp_seen;
        int exp_kp;
        logic [3:0] exp_col;
        keys = k;
        kp_seen = 0;
        for (int s = 1; s <= FRAME; s++) begin
            @(posedge clk); #1;
            exp_col = ~(4'b0001 << ((s / SD) % 4));
            check({tag, ".col"}, 16'(col), 16'(exp_col));
            kp_seen += int'(kp);
        end
        model_frame(k, exp_kp);
        check({tag, ".kp"}, 16'(kp_seen), 16'(exp_kp));
        check({tag, ".en"}, 16'(en), 16'(m_held));
        check({tag, ".b"},  16'(b), 16'(m_b));
    endtask

    // Lock onto the column-3 to column-0 transition (frame boundary)
    task automatic align();
        logic [3:0] prev;
        bit found;
        prev = col;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #1;
            if (prev == 4'b0111 && col == 4'b1110) found = 1;
            prev = col;
        end
        if (!found) begin
            n_checks++; n_fail++;
            $display("FAIL align observed=no_frame_boundary expected=boundary_within_200_cycles");
            $fatal(1, "scan never wrapped");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_kp;
        logic [15:0] k;
        int r;

        // Reset values
        keys = 16'h0;
        rst_n = 1'b0;
        #200;
        check("rst.col", 16'(col), 16'h000E);
        check("rst.b",   16'(b),   16'h0);
        check("rst.en",  16'(en),  16'h0);
        check("rst.kp",  16'(kp),  16'h0);
        rst_n = 1'b1;
        align();
        model_reset();
        for (int f = 0; f < 2; f++) run_frame(16'h0, "idle");

        // Press key 3 (col0,row3), hold, then release
        for (int f = 0; f < 5; f++) run_frame(16'h0008, "press3");
        for (int f = 0; f < 4; f++) run_frame(16'h0, "rel3");

        // Bounce on key 5
        for (int f = 0; f < 2; f++) run_frame(16'h0020, "bnc5a");
        run_frame(16'h0, "bnc5gap");
        for (int f = 0; f < 4; f++) run_frame(16'h0020, "bnc5b");
        for (int f = 0; f < 4; f++) run_frame(16'h0, "rel5");

        // Keys 9 and 6 together, then 9 alone
        for (int f = 0; f < 4; f++) run_frame(16'h0240, "k9k6");
        for (int f = 0; f < 7; f++) run_frame(16'h0200, "k9");
        for (int f = 0; f < 4; f++) run_frame(16'h0, "rel9");

        // Reset while holding key 12
        for (int f = 0; f < 4; f++) run_frame(16'h1000, "k12");
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst.en",  16'(en),  16'h0);
        check("midrst.b",   16'(b),   16'h0);
        check("midrst.col", 16'(col), 16'h000E);
        check("midrst.kp",  16'(kp),  16'h0);
        #30;
        rst_n = 1'b1;
        model_reset();
        align();
        model_frame(keys, exp_kp);
        check("rerst.en", 16'(en), 16'(m_held));
        check("rerst.b",  16'(b),  16'(m_b));
        for (int f = 0; f < 4; f++) run_frame(16'h1000, "k12re");

        // Randomised key activity
        k = 16'h0;
        for (int f = 0; f < 60; f++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5) begin
                // keep the previous pattern
            end else if (r < 7) begin
                k = 16'h0;
            end else begin
                k = 16'(1 << $urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1) k = k | 16'(1 << $urandom_range(0, 15));
            end
            run_frame(k, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/key_matrix_scanner.md
Name: key_matrix_scanner

Overview:
- Upstream stage of the tone path. Scans the 4x4 launchpad key matrix, synchronises and debounces the row returns, and encodes the held key as a 4-bit note code.
- B_out and EN_out connect directly to the tone converter's B_in and EN inputs.
- KEY_PRESS gives a one-cycle strobe per accepted press, for display and recording logic.

Parameters:
- SCAN_DIV, 16: clock cycles each column stays driven. Legal values 4..65535.
- DEBOUNCE_CNT, 8: consecutive identical full-scan frames required to accept a press, and likewise to accept a release. Legal values 1..255.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- ROW_in  in  4  matrix row returns, active-low, pulled up off-chip; asynchronous.
- COL_out  out  4  column drive, one-hot active-low.
- B_out  out  4  note code of the accepted key.
- EN_out  out  1  high while an accepted key is held.
- KEY_PRESS  out  1  one-cycle pulse on each accepted press.

Behaviour:
- Reset (async assert, sync deassert inside the block): COL_out=4'b1110, B_out=0, EN_out=0, KEY_PRESS=0. Scan slot = column 0, divider=0, debounce FSM = IDLE, counters=0, synchroniser flops=4'b1111.
- Input synchroniser: ROW_in passes through 2 flops before use.
- Scan timing:
  - Divider counts 0..SCAN_DIV-1. Column c (0..3) drives COL_out[c]=0 for one full divider period.
  - Synchronised rows are sampled when divider==SCAN_DIV-1. This cycle is ≥3 cycles after the column change, which covers settle time plus the 2-flop delay.
  - Columns advance 0→1→2→3→0 and wrap without gaps.
- Frame: the 4 column slots = 4*SCAN_DIV cycles. Frame ends at the column-3 sample.
- Frame result:
  - valid=1 if any sampled row bit was 0.
  - code = 4*col + row of the lowest-numbered pressed key; multiple keys → lowest code wins.
  - Result is computed combinationally from 16 per-frame key bits, which are cleared at frame start.
- Debounce FSM (evaluated once per frame end; otherwise holds):
  - IDLE:
    - valid → CAND, cand=code, cnt=1.
    - If DEBOUNCE_CNT==1, go straight to HELD instead and perform the accept actions.
  - CAND:
    - valid and code==cand → cnt+1. When cnt reaches DEBOUNCE_CNT → HELD and accept.
    - valid and code!=cand → cand=code, cnt=1.
    - !valid → IDLE.
  - Accept actions: B_out=cand, EN_out=1, KEY_PRESS=1 for exactly one cycle.
  - HELD:
    - valid and code==B_out → rcnt=0.
    - Otherwise rcnt+1. When rcnt reaches DEBOUNCE_CNT → IDLE, EN_out=0.
    - B_out keeps its last value after release.
    - A different key held steadily therefore releases the old key after DEBOUNCE_CNT frames and is accepted after DEBOUNCE_CNT further frames. There is no direct key-to-key switch.
- Latency: outputs update on the CLK edge after the qualifying frame-end sample. Press-to-EN_out ≤ (DEBOUNCE_CNT+1) frames + 3 cycles.
- Bounce: a single glitch frame inside CAND returns the FSM to IDLE or restarts it; inside HELD, one bad frame does not release.
- Reset mid-scan or mid-HELD: immediate return to the reset values above. EN_out falls asynchronously.
- Widths:
  - Divider is 16-bit; cnt and rcnt are 8-bit; none of them wraps.
  - rcnt and cnt saturate at DEBOUNCE_CNT because the FSM transitions at that count.

Decomposition:
- Shared package (tone_pkg): NOTE_W=4, NUM_ROWS=4, NUM_COLS=4, and the debounce state enum IDLE/CAND/HELD.
- One sub-module, key_debouncer: holds the FSM plus cnt/rcnt. Its inputs are frame_end, valid and code; its outputs are B_out, EN_out and KEY_PRESS.
- The scanner top holds the divider, column drive, synchroniser and frame encoder.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3; frame=16 cycles):
- Reset, RST_N=0 for 200 ns then 1, no keys → COL_out cycles 1110,1101,1011,0111 every 4 cycles. EN_out=0, B_out=0, KEY_PRESS=0 throughout.
- Press key col0,row3 (ROW_in[3]=0 while COL_out[0]=0) steadily → B_out=4'b0011, EN_out=1 after the 3rd complete frame. Exactly one KEY_PRESS pulse; EN_out stays 1 while held.
- Release after hold → EN_out=0 after 3 empty frames; B_out stays 0011; no KEY_PRESS pulse.
- Bounce: key 5 present for 2 frames, absent 1, present 3 → a single accept only after the final 3 frames; no early EN_out.
- Keys 9 and 6 held together → B_out=6. Then drop key 6 and keep key 9 → release after 3 frames, accept 9 after 3 more, second KEY_PRESS pulse.
- RST_N pulsed low while HELD on key 12 → outputs clear immediately. After RST_N returns high with key 12 still held, the block re-accepts it after 3 frames.
